// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : unified_mem_arbiter
//  Purpose  : Shares one single-ported, variable-latency unified memory
//             between the F-stage fetch port and the M-stage data port.
//             Data accesses win arbitration, but a saturating starvation
//             counter forces a fetch grant after STARVE_MAX consecutive
//             data grants made while a fetch was waiting. Combinational
//             stall requests freeze the front end (stall_f) or the whole
//             pipe (stall_m) while a port waits for memory.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst                    rising-edge clock, sync active-high reset
//    if_req/if_addr              fetch request (held until if_ack)
//    if_rdata/if_ack             fetched word, one-cycle completion pulse
//    dm_req/dm_we/dm_addr/dm_wdata  data request (held until dm_ack)
//    dm_rdata/dm_ack             load data, one-cycle completion pulse
//    mem_en/mem_we/mem_addr/mem_wdata  one-cycle command to memory
//    mem_rdata/mem_valid         memory response (>=1 cycle after mem_en)
//    stall_f, stall_m            hazard-unit stall requests
// ============================================================================
module unified_mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_valid,
  output logic          stall_f,
  output logic          stall_m
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_I    = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [1:0]    state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic [3:0]    starve_cnt_q, starve_cnt_d;
  logic          if_ack_q, if_ack_d;
  logic          dm_ack_q, dm_ack_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;
  logic          data_wins;

  // Data wins unless a fetch is waiting and has already been passed over
  // STARVE_MAX times in a row.
  assign data_wins = dm_req && ((starve_cnt_q < STARVE_LIM) || !if_req);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    starve_cnt_d = starve_cnt_q;
    if_ack_d     = 1'b0;
    dm_ack_d     = 1'b0;
    mem_en_d     = 1'b0;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (data_wins) begin
          // Command fields are captured here so the requester only has to
          // hold them up to the grant edge.
          owner_d     = OWN_D;
          state_d     = ST_ISSUE;
          mem_en_d    = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          if (if_req) begin
            starve_cnt_d = (starve_cnt_q >= STARVE_LIM) ? STARVE_LIM
                                                        : starve_cnt_q + 4'd1;
          end else begin
            starve_cnt_d = 4'd0;
          end
        end else if (if_req) begin
          owner_d      = OWN_I;
          state_d      = ST_ISSUE;
          mem_en_d     = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = if_addr;
          starve_cnt_d = 4'd0;
        end
      end
      ST_ISSUE: begin
        // Write enable is confined to the single command cycle.
        mem_we_d = 1'b0;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_valid) begin
          state_d = ST_RESP;
          if (owner_q == OWN_D) begin
            dm_rdata_d = mem_rdata;
            dm_ack_d   = 1'b1;
          end else begin
            if_rdata_d = mem_rdata;
            if_ack_d   = 1'b1;
          end
        end
      end
      ST_RESP: begin
        // The ack is visible this cycle; requests are not re-sampled here.
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_NONE;
      starve_cnt_q <= 4'd0;
      if_ack_q     <= 1'b0;
      dm_ack_q     <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
      if_ack_q     <= if_ack_d;
      dm_ack_q     <= dm_ack_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
    end
  end

  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  assign stall_f = if_req & ~if_ack_q;
  assign stall_m = dm_req & ~dm_ack_q;

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_unified_mem_arbiter
//  Purpose  : Directed self-checking bench for unified_mem_arbiter with a
//             behavioural variable-latency memory.
//  Revision : 1.0  initial release
// ============================================================================
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_valid = 1'b0;
  logic        stall_f;
  logic        stall_m;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  unified_mem_arbiter #(.AW(32), .DW(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .stall_f(stall_f), .stall_m(stall_m)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural memory, latency k_lat >= 1 ----------------
  int          k_lat = 1;
  int          pend_cnt = 0;
  bit          pend = 1'b0;
  logic [7:0]  pend_addr = '0;
  bit          wr_valid [0:255];
  logic [31:0] wr_data  [0:255];

  function automatic logic [31:0] default_word(input logic [7:0] a);
    if (a == 8'h10) return 32'h8C22_0004;
    return 32'hA000_0000 | {24'h0, a};
  endfunction

  always @(posedge clk) begin
    mem_valid <= 1'b0;
    if (mem_en) begin
      if (mem_we) begin
        wr_valid[mem_addr[7:0]] = 1'b1;
        wr_data[mem_addr[7:0]]  = mem_wdata;
      end
      pend_addr = mem_addr[7:0];
      pend      = 1'b1;
      pend_cnt  = k_lat - 1;
    end else if (pend && pend_cnt > 0) begin
      pend_cnt = pend_cnt - 1;
    end
    if (pend && pend_cnt == 0) begin
      mem_valid <= 1'b1;
      mem_rdata <= wr_valid[pend_addr] ? wr_data[pend_addr] : default_word(pend_addr);
      pend = 1'b0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
    cyc++;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    rst = 1'b0;
    n_tests++;
    if ({if_ack, dm_ack, mem_en, mem_we} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b required 0000", {if_ack, dm_ack, mem_en, mem_we});
    end
    n_tests++;
    if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'h0) begin
      n_fail++; $display("FAIL reset_data: got %h required 0", {mem_addr, mem_wdata, if_rdata, dm_rdata});
    end
    n_tests++;
    if (dut.state_q !== 2'd0 || dut.starve_cnt_q !== 4'd0 || dut.owner_q !== 2'd0) begin
      n_fail++; $display("FAIL reset_state: got state=%0d cnt=%0d owner=%0d required 0/0/0",
                         dut.state_q, dut.starve_cnt_q, dut.owner_q);
    end
    tick;
    n_tests++;
    if ({mem_en, stall_f, stall_m} !== 3'b0) begin
      n_fail++; $display("FAIL idle_quiet: got %b required 000", {mem_en, stall_f, stall_m});
    end
  endtask

  task automatic test_single_fetch;
    k_lat = 2;
    if_addr = 32'h10; if_req = 1'b1;
    #1;
    n_tests++;
    if (stall_f !== 1'b1) begin n_fail++; $display("FAIL fetch_stall_c0: got %b required 1", stall_f); end
    tick; // c1
    n_tests++;
    if ({mem_en, mem_we} !== 2'b10 || mem_addr !== 32'h10 || stall_f !== 1'b1) begin
      n_fail++; $display("FAIL fetch_issue: got en=%b we=%b addr=%h stall=%b required 1 0 10 1",
                         mem_en, mem_we, mem_addr, stall_f);
    end
    tick; // c2
    n_tests++;
    if (mem_en !== 1'b0 || stall_f !== 1'b1) begin
      n_fail++; $display("FAIL fetch_c2: got en=%b stall=%b required 0 1", mem_en, stall_f);
    end
    tick; // c3
    n_tests++;
    if (if_ack !== 1'b0 || stall_f !== 1'b1) begin
      n_fail++; $display("FAIL fetch_c3: got ack=%b stall=%b required 0 1", if_ack, stall_f);
    end
    tick; // c4
    n_tests++;
    if (if_ack !== 1'b1 || dm_ack !== 1'b0 || if_rdata !== 32'h8C22_0004 || stall_f !== 1'b0) begin
      n_fail++; $display("FAIL fetch_ack: got ack=%b dack=%b rdata=%h stall=%b required 1 0 8c220004 0",
                         if_ack, dm_ack, if_rdata, stall_f);
    end
    if_req = 1'b0;
    tick; // c5
    n_tests++;
    if (if_ack !== 1'b0) begin n_fail++; $display("FAIL fetch_ack_pulse: got %b required 0", if_ack); end
  endtask

  task automatic test_store_load;
    int we_cnt;
    bit got;
    k_lat = 1;
    we_cnt = 0;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h20; dm_wdata = 32'hDEAD_BEEF;
    tick;
    we_cnt += int'(mem_we);
    n_tests++;
    if ({mem_en, mem_we} !== 2'b11 || mem_addr !== 32'h20 || mem_wdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL store_issue: got en=%b we=%b addr=%h wdata=%h required 1 1 20 deadbeef",
                         mem_en, mem_we, mem_addr, mem_wdata);
    end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick; we_cnt += int'(mem_we);
      if (dm_ack) got = 1'b1;
    end
    n_tests++;
    if (!got || if_ack !== 1'b0) begin
      n_fail++; $display("FAIL store_ack: got ack_seen=%b if_ack=%b required 1 0", got, if_ack);
    end
    dm_req = 1'b0; dm_we = 1'b0;
    tick; we_cnt += int'(mem_we);
    dm_req = 1'b1; dm_addr = 32'h20; dm_wdata = 32'h0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick; we_cnt += int'(mem_we);
      if (dm_ack) got = 1'b1;
    end
    n_tests++;
    if (!got || dm_rdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL load_data: got ack_seen=%b rdata=%h required 1 deadbeef", got, dm_rdata);
    end
    dm_req = 1'b0;
    n_tests++;
    if (we_cnt != 1) begin n_fail++; $display("FAIL we_cycles: got %0d required 1", we_cnt); end
    tick;
  endtask

  task automatic test_contention;
    int en_n, en_c1, en_c2, dack_c, iack_c;
    logic [31:0] en_a1, en_a2, irdata, drdata;
    bit overlap;
    k_lat = 1;
    en_n = 0; en_c1 = -1; en_c2 = -1; dack_c = -1; iack_c = -1;
    en_a1 = '0; en_a2 = '0; irdata = '0; drdata = '0; overlap = 1'b0;
    if_addr = 32'h30; if_req = 1'b1;
    dm_addr = 32'h40; dm_we = 1'b0; dm_req = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick;
      if (mem_en) begin
        if (en_n == 0) begin en_c1 = c; en_a1 = mem_addr; end
        else if (en_n == 1) begin en_c2 = c; en_a2 = mem_addr; end
        en_n++;
      end
      if (if_ack && dm_ack) overlap = 1'b1;
      if (dm_ack) begin dack_c = c; drdata = dm_rdata; dm_req = 1'b0; end
      if (if_ack) begin iack_c = c; irdata = if_rdata; if_req = 1'b0; end
    end
    n_tests++;
    if (en_c1 != 1 || en_a1 !== 32'h40) begin
      n_fail++; $display("FAIL cont_first_grant: got c=%0d addr=%h required c=1 addr=40", en_c1, en_a1);
    end
    n_tests++;
    if (dack_c != 3 || drdata !== 32'hA000_0040) begin
      n_fail++; $display("FAIL cont_dack: got c=%0d rdata=%h required c=3 a0000040", dack_c, drdata);
    end
    n_tests++;
    if (en_c2 != 5 || en_a2 !== 32'h30) begin
      n_fail++; $display("FAIL cont_fetch_grant: got c=%0d addr=%h required c=5 addr=30", en_c2, en_a2);
    end
    n_tests++;
    if (iack_c != 7 || irdata !== 32'hA000_0030) begin
      n_fail++; $display("FAIL cont_iack: got c=%0d rdata=%h required c=7 a0000030", iack_c, irdata);
    end
    n_tests++;
    if (overlap || en_n != 2) begin
      n_fail++; $display("FAIL cont_overlap: got overlap=%b grants=%0d required 0 2", overlap, en_n);
    end
  endtask

  task automatic test_starvation;
    int data_before, data_grants, fetch_grants, data_after;
    logic [3:0] cnt_at_iack, cnt_peak;
    bit done;
    k_lat = 1;
    data_before = -1; data_grants = 0; fetch_grants = 0; data_after = 0;
    cnt_at_iack = 4'hF; cnt_peak = 4'h0; done = 1'b0;
    if_addr = 32'h50; if_req = 1'b1;
    dm_addr = 32'h60; dm_we = 1'b0; dm_req = 1'b1;
    for (int c = 1; c <= 100 && !done; c++) begin
      tick;
      if (dut.starve_cnt_q > cnt_peak) cnt_peak = dut.starve_cnt_q;
      if (mem_en) begin
        if (mem_addr == 32'h50) begin
          if (fetch_grants == 0) data_before = data_grants;
          fetch_grants++;
        end else begin
          data_grants++;
          if (fetch_grants > 0) data_after++;
        end
      end
      if (if_ack) begin if_req = 1'b0; cnt_at_iack = dut.starve_cnt_q; end
      if (dm_ack && data_after >= 1) begin dm_req = 1'b0; done = 1'b1; end
    end
    n_tests++;
    if (!done) begin n_fail++; $display("FAIL starve_timeout: got done=0 required 1"); end
    n_tests++;
    if (data_before != 4 || fetch_grants != 1) begin
      n_fail++; $display("FAIL starve_order: got data_before=%0d fetches=%0d required 4 1",
                         data_before, fetch_grants);
    end
    n_tests++;
    if (cnt_peak !== 4'd4 || cnt_at_iack !== 4'd0) begin
      n_fail++; $display("FAIL starve_cnt: got peak=%0d at_iack=%0d required 4 0", cnt_peak, cnt_at_iack);
    end
    n_tests++;
    if (data_after != 1 || dut.starve_cnt_q !== 4'd0) begin
      n_fail++; $display("FAIL starve_resume: got data_after=%0d cnt=%0d required 1 0",
                         data_after, dut.starve_cnt_q);
    end
    tick;
  endtask

  task automatic test_reset_in_wait;
    bit ack_seen, valid_seen, not_idle;
    k_lat = 3;
    ack_seen = 1'b0; valid_seen = 1'b0; not_idle = 1'b0;
    if_addr = 32'h70; if_req = 1'b1;
    tick; // c1 ISSUE
    tick; // c2 WAIT
    n_tests++;
    if (dut.state_q !== 2'd2) begin n_fail++; $display("FAIL rstw_in_wait: got %0d required 2", dut.state_q); end
    rst = 1'b1; if_req = 1'b0;
    tick; // c3 reset applied
    rst = 1'b0;
    n_tests++;
    if ({if_ack, dm_ack, mem_en, mem_we} !== 4'b0 ||
        {mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'h0 || dut.state_q !== 2'd0) begin
      n_fail++; $display("FAIL rstw_regs: got ctl=%b data=%h state=%0d required 0 0 0",
                         {if_ack, dm_ack, mem_en, mem_we}, {mem_addr, mem_wdata, if_rdata, dm_rdata},
                         dut.state_q);
    end
    for (int i = 0; i < 6; i++) begin
      tick;
      if (if_ack || dm_ack) ack_seen = 1'b1;
      if (mem_valid) valid_seen = 1'b1;
      if (dut.state_q !== 2'd0) not_idle = 1'b1;
    end
    n_tests++;
    if (ack_seen || !valid_seen || not_idle) begin
      n_fail++; $display("FAIL rstw_late_valid: got ack=%b valid=%b left_idle=%b required 0 1 0",
                         ack_seen, valid_seen, not_idle);
    end
  endtask

  task automatic test_back_to_back;
    int ack_c [0:2];
    logic [31:0] en_a [0:2];
    logic [31:0] rd [0:2];
    bit got;
    k_lat = 1;
    for (int i = 0; i < 3; i++) begin
      ack_c[i] = -1; en_a[i] = 32'hFFFF_FFFF; rd[i] = '0;
      if_addr = 32'(i); if_req = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        tick;
        if (mem_en) en_a[i] = mem_addr;
        if (if_ack) begin got = 1'b1; ack_c[i] = cyc; rd[i] = if_rdata; end
      end
      if_req = 1'b0;
      tick;
    end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (en_a[i] !== 32'(i) || rd[i] !== (32'hA000_0000 | 32'(i)) || ack_c[i] < 0) begin
        n_fail++; $display("FAIL b2b_%0d: got addr=%h rdata=%h ack_c=%0d required addr=%h rdata=%h",
                           i, en_a[i], rd[i], ack_c[i], 32'(i), 32'hA000_0000 | 32'(i));
      end
    end
    n_tests++;
    if (ack_c[1] - ack_c[0] != 4 || ack_c[2] - ack_c[1] != 4) begin
      n_fail++; $display("FAIL b2b_spacing: got %0d %0d required 4 4",
                         ack_c[1] - ack_c[0], ack_c[2] - ack_c[1]);
    end
  endtask

  initial begin
    test_reset;
    test_single_fetch;
    tick;
    test_store_load;
    tick;
    test_contention;
    tick;
    test_starvation;
    tick;
    test_reset_in_wait;
    tick;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported, variable-latency unified memory between the F-stage instruction fetch port and the M-stage data port of the 5-stage pipeline.
- Data accesses have priority over fetches. A starvation counter forces a fetch grant after a run of back-to-back data grants.
- Drives stall requests into the hazard logic so that the PC/DReg (fetch) or the whole pipe (data) freezes while a port waits for memory.

Parameters:
- AW, 32, address width; addresses are word addresses, so PC increments by 1.
- DW, 32, data width.
- STARVE_MAX, 4, maximum consecutive data grants while a fetch is pending before fetch is forced; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  AW  fetch address (PCF).
- if_rdata  out  DW  fetched instruction; valid only while if_ack=1.
- if_ack  out  1  one-cycle fetch completion pulse.
- dm_req  in  1  data request; held high until dm_ack.
- dm_we  in  1  1=store, 0=load.
- dm_addr  in  AW  data address (ALUOutM).
- dm_wdata  in  DW  store data (DMdinM).
- dm_rdata  out  DW  load data; valid only while dm_ack=1.
- dm_ack  out  1  one-cycle data completion pulse (loads and stores).
- mem_en  out  1  one-cycle command strobe to memory.
- mem_we  out  1  write enable, qualified by mem_en.
- mem_addr  out  AW  memory address, qualified by mem_en.
- mem_wdata  out  DW  memory write data, qualified by mem_en.
- mem_rdata  in  DW  memory read data, valid with mem_valid.
- mem_valid  in  1  memory completion pulse, at least 1 cycle after mem_en.
- stall_f  out  1  if_req & ~if_ack (combinational).
- stall_m  out  1  dm_req & ~dm_ack (combinational).

Behaviour:
- Reset values:
  - All registered outputs are 0: if_ack, dm_ack, mem_en, mem_we, mem_addr, mem_wdata, if_rdata, dm_rdata.
  - Internal state: state=IDLE, starve_cnt=0, owner=NONE.
- FSM states and transitions:
  - IDLE: arbitrate.
    - dm_req and (starve_cnt<STARVE_MAX or !if_req): owner=D; go ISSUE.
    - Otherwise if_req: owner=I; go ISSUE.
    - Otherwise stay in IDLE.
  - ISSUE (exactly 1 cycle):
    - mem_en=1; mem_addr/mem_we/mem_wdata come from the owner's inputs captured at the IDLE edge.
    - A fetch always drives mem_we=0.
    - Go WAIT.
  - WAIT:
    - Hold until mem_valid=1.
    - On mem_valid, latch mem_rdata into the owner's rdata register; go RESP.
    - mem_valid arriving in the ISSUE cycle is illegal and ignored.
  - RESP (exactly 1 cycle):
    - The owner's ack=1; go IDLE.
    - The owner's req is not sampled in RESP. A requester sees ack, then drops req or presents a new request the following cycle.
- Latency:
  - Request sampled in IDLE at edge N gives mem_en during cycle N+1.
  - mem_valid at cycle N+1+k (k>=1) gives ack during cycle N+2+k.
  - Minimum request-to-ack is 3 cycles at k=1.
- Inputs are registered at grant; the requester must hold addr/data stable only until the grant edge.
- starve_cnt (4 bits, saturating at STARVE_MAX):
  - Increments on each data grant made while if_req=1.
  - Clears on any fetch grant, and on a data grant made while if_req=0.
- Simultaneous if_req and dm_req in IDLE: data wins unless starve_cnt==STARVE_MAX, in which case fetch wins.
- Store completion: dm_ack still waits for mem_valid. dm_rdata is undefined for stores but registered, so it holds the last mem_rdata.
- Exactly one outstanding memory transaction; mem_en never asserts outside ISSUE.
- Reset mid-transaction:
  - Return to IDLE and abandon the outstanding access; no ack is generated.
  - A late mem_valid seen in IDLE is ignored.
- A request that drops before its ack (protocol violation) does not cancel an in-flight access; the ack still pulses.
- if_ack and dm_ack are never high in the same cycle.

Test Plan:
- Single fetch: if_req=1, if_addr=0x10, memory k=2 returning 0x8C220004 -> mem_en at cycle 1 with addr 0x10 and we=0; if_ack=1 with if_rdata=0x8C220004 at cycle 4; stall_f=1 during cycles 0-3.
- Store then load: dm_req/dm_we=1, addr 0x20, wdata 0xDEADBEEF; then load from 0x20 -> second dm_ack returns dm_rdata=0xDEADBEEF; mem_we=1 only during the store's ISSUE cycle.
- Contention: if_req and dm_req both raised at cycle 0 -> data granted first (mem_addr=dm_addr); fetch granted at the IDLE cycle after dm_ack; acks never overlap.
- Starvation (STARVE_MAX=4): if_req held high, dm_req re-raised immediately after every ack -> exactly 4 data transactions, then 1 fetch, then starve_cnt=0 and data resumes.
- Reset in WAIT: assert rst for 1 cycle while in WAIT, then memory pulses mem_valid -> no if_ack/dm_ack, state=IDLE, all registered outputs are 0 after the reset edge.
- Back-to-back fetches at k=1: if_req re-raised in the cycle after each ack for addresses 0,1,2 -> acks every 4 cycles, mem_addr sequence 0,1,2.
